// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Scan FSM: IDLE (display off), BLANK (inter-digit guard), SHOW (digit lit).
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_e;

  // Segment order is {a,b,c,d,e,f,g}; 1 = segment lit.
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;

endpackage

// File: rtl/seven_seg_dec.sv
// BCD to {a..g} segment decoder; codes 10..15 render as all-off.
// Latency: purely combinational.
// Backpressure: none.
module seven_seg_dec
  import seven_seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Table lookup of the segment pattern for one BCD digit.
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Multiplexed 7-segment scanner with shadow/active digit banks committed per frame.
// Latency: wr_ack one cycle after wr_en; seg/dig_sel registered, both move on the same edge.
// Backpressure: none; a write is accepted every cycle, out-of-range addresses are dropped.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  blank_lz,
  input  logic                  wr_en,
  input  logic [2:0]            wr_addr,
  input  logic [3:0]            wr_data,
  output logic                  wr_ack,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_tick
);

  localparam int IDXW    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [CNTW-1:0]       SHOW_LAST  = CNTW'(PRESCALE - 1);
  localparam logic [CNTW-1:0]       BLANK_LAST = CNTW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDXW-1:0]       IDX_LAST   = IDXW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE    = NUM_DIGITS'(1);
  // With no guard configured, every digit boundary goes straight to the next SHOW.
  localparam scan_state_e           NEXT_SEG   = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  scan_state_e                     state_q, state_d;
  logic [IDXW-1:0]                 idx_q, idx_d;
  logic [CNTW-1:0]                 cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0][3:0]      active_q, active_d;
  logic [6:0]                      seg_q, seg_d;
  logic [NUM_DIGITS-1:0]           dig_sel_q, dig_sel_d;
  logic                            wr_ack_q, wr_ack_d;
  logic                            frame_tick_q, frame_tick_d;

  logic                            commit;
  logic [3:0]                      cur_bcd;
  logic                            cur_zero_up;
  logic                            zero_run;
  logic                            suppress;
  logic [6:0]                      dec_seg;

  // Host write port: update the shadow bank and acknowledge in-range addresses.
  always_comb begin
    shadow_d = shadow_q;
    wr_ack_d = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (wr_en && (wr_addr == 3'(i))) begin
        shadow_d[i] = wr_data;
        wr_ack_d    = 1'b1;
      end
    end
  end

  // Scan FSM next-state: guard/show timing, digit advance and frame commit.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q + CNTW'(1);
    commit       = 1'b0;
    frame_tick_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (enable) begin
          state_d = NEXT_SEG;
        end
      end
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = SHOW;
          cnt_d   = '0;
        end
      end
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = NEXT_SEG;
          cnt_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d        = '0;
            commit       = 1'b1;
            frame_tick_d = 1'b1;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
    // Dropping enable aborts the frame without committing.
    if (!enable) begin
      state_d      = IDLE;
      idx_d        = '0;
      cnt_d        = '0;
      commit       = 1'b0;
      frame_tick_d = 1'b0;
    end
  end

  // Active bank tracks the shadow while idle and at each commit; the post-write
  // shadow is used so a write landing on the commit edge is included.
  always_comb begin
    active_d = active_q;
    if ((state_q == IDLE) || commit) begin
      active_d = shadow_d;
    end
  end

  // Select the next digit to display and whether it and all higher digits are zero.
  always_comb begin
    cur_bcd     = 4'd0;
    cur_zero_up = 1'b0;
    zero_run    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (active_d[i] == 4'd0);
      if (idx_d == IDXW'(i)) begin
        cur_bcd     = active_d[i];
        cur_zero_up = zero_run;
      end
    end
  end

  assign suppress = blank_lz && (idx_d != '0) && cur_zero_up;

  seven_seg_dec u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  // Output pattern for the coming cycle, derived from next state so seg and dig_sel align.
  always_comb begin
    seg_d     = SEG_BLANK;
    dig_sel_d = '0;
    if (state_d == SHOW) begin
      dig_sel_d = SEL_ONE << idx_d;
      if (!suppress) begin
        seg_d = dec_seg;
      end
    end
  end

  // State, register banks and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      active_q     <= '0;
      seg_q        <= SEG_BLANK;
      dig_sel_q    <= '0;
      wr_ack_q     <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      dig_sel_q    <= dig_sel_d;
      wr_ack_q     <= wr_ack_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign seg        = seg_q;
  assign dig_sel    = dig_sel_q;
  assign wr_ack     = wr_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with a scoreboard of expected digit patterns.
// Latency: n/a.
// Backpressure: n/a.
module tb_seven_seg_scan;

  localparam int NUM_DIGITS   = 4;
  localparam int PRESCALE     = 4;
  localparam int BLANK_CYCLES = 1;

  localparam logic [6:0] P0   = 7'b1111110;
  localparam logic [6:0] P1   = 7'b0110000;
  localparam logic [6:0] P2   = 7'b1101101;
  localparam logic [6:0] P3   = 7'b1111001;
  localparam logic [6:0] P4   = 7'b0110011;
  localparam logic [6:0] P5   = 7'b1011011;
  localparam logic [6:0] P7   = 7'b1110000;
  localparam logic [6:0] P9   = 7'b1111011;
  localparam logic [6:0] POFF = 7'b0000000;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
  } sb_t;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  enable;
  logic                  blank_lz;
  logic                  wr_en;
  logic [2:0]            wr_addr;
  logic [3:0]            wr_data;
  logic                  wr_ack;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] dig_sel;
  logic                  frame_tick;

  sb_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  seven_seg_scan #(
    .NUM_DIGITS   (NUM_DIGITS),
    .PRESCALE     (PRESCALE),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] sel, input logic [6:0] s);
    sb_t e;
    e.sel = sel;
    e.seg = s;
    exp_q.push_back(e);
  endtask

  // One host write issued at a negedge; the ack is sampled at the following negedge.
  task automatic do_write(input string tag, input logic [2:0] a, input logic [3:0] d,
                          input logic exp_ack);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
    check_eq({tag, "_ack"}, {31'd0, wr_ack}, {31'd0, exp_ack});
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!frame_tick && n < 60);
    check_eq({tag, "_tick"}, {31'd0, frame_tick}, 32'd1);
  endtask

  // Pop one expectation per lit digit of the coming frame; also checks each digit's dwell.
  task automatic check_frame(input string tag);
    sb_t e;
    int  n;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      n = 0;
      while (dig_sel == '0 && n < 20) begin
        @(negedge clock);
        n++;
      end
      check_eq({tag, "_sb_nonempty"}, {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq({tag, "_sel"}, {28'd0, dig_sel}, {28'd0, e.sel});
        check_eq({tag, "_seg"}, {25'd0, seg}, {25'd0, e.seg});
        n = 0;
        while (dig_sel == e.sel && n < 20) begin
          @(negedge clock);
          n++;
        end
        check_eq({tag, "_dwell"}, n, PRESCALE);
      end
    end
  endtask

  initial begin
    int first_tick;
    int n;
    int ticks;
    int lit;

    reset    = 1'b0;
    enable   = 1'b0;
    blank_lz = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 4'd0;

    // Reset state.
    repeat (3) @(negedge clock);
    check_eq("rst_seg", {25'd0, seg}, 32'd0);
    check_eq("rst_sel", {28'd0, dig_sel}, 32'd0);
    check_eq("rst_ack", {31'd0, wr_ack}, 32'd0);
    check_eq("rst_tick", {31'd0, frame_tick}, 32'd0);

    // First frame after enable, with writes 1,2,3,4 landing mid-frame.
    reset      = 1'b1;
    enable     = 1'b1;
    first_tick = 0;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clock);
      if (frame_tick && first_tick == 0) first_tick = c;
      if (c == 1) check_eq("ff_blank0", {28'd0, dig_sel}, 32'd0);
      if (c == 2) begin
        check_eq("ff_sel0", {28'd0, dig_sel}, 32'b0001);
        check_eq("ff_seg0", {25'd0, seg}, {25'd0, P0});
      end
      if (c == 5) check_eq("ff_sel0_hold", {28'd0, dig_sel}, 32'b0001);
      if (c == 6) check_eq("ff_blank1", {28'd0, dig_sel}, 32'd0);
      if (c == 7 || c == 12 || c == 17) check_eq("ff_still_zero", {25'd0, seg}, {25'd0, P0});
      if (c == 17) check_eq("ff_sel3", {28'd0, dig_sel}, 32'b1000);
      if (c >= 2 && c <= 7) check_eq("ff_ack", {31'd0, wr_ack}, {31'd0, (c >= 3 && c <= 6)});
      if (c >= 2 && c <= 5) begin
        wr_en   = 1'b1;
        wr_addr = 3'(c - 2);
        wr_data = 4'(c - 1);
      end else begin
        wr_en = 1'b0;
      end
    end
    check_eq("ff_first_tick", first_tick, 21);

    push_exp(4'b0001, P1);
    push_exp(4'b0010, P2);
    push_exp(4'b0100, P3);
    push_exp(4'b1000, P4);
    check_frame("f1234");

    // Out-of-range write is dropped; code 0xA renders blank.
    do_write("wr_addr5", 3'd5, 4'd9, 1'b0);
    do_write("wr_addr2_A", 3'd2, 4'hA, 1'b1);
    wait_tick("fA");
    push_exp(4'b0001, P1);
    push_exp(4'b0010, P2);
    push_exp(4'b0100, POFF);
    push_exp(4'b1000, P4);
    check_frame("fA");

    // Leading-zero suppression: {0,0,0,7}.
    blank_lz = 1'b1;
    do_write("lz_w3", 3'd3, 4'd0, 1'b1);
    do_write("lz_w2", 3'd2, 4'd0, 1'b1);
    do_write("lz_w1", 3'd1, 4'd0, 1'b1);
    do_write("lz_w0", 3'd0, 4'd7, 1'b1);
    wait_tick("lz1");
    push_exp(4'b0001, P7);
    push_exp(4'b0010, POFF);
    push_exp(4'b0100, POFF);
    push_exp(4'b1000, POFF);
    check_frame("lz1");

    // Leading-zero suppression: {0,5,0,0} blanks only digit 3.
    do_write("lz_w0b", 3'd0, 4'd0, 1'b1);
    do_write("lz_w2b", 3'd2, 4'd5, 1'b1);
    wait_tick("lz2");
    push_exp(4'b0001, P0);
    push_exp(4'b0010, P0);
    push_exp(4'b0100, P5);
    push_exp(4'b1000, POFF);
    check_frame("lz2");
    blank_lz = 1'b0;

    // Abort during SHOW of digit 2.
    n = 0;
    while (dig_sel != 4'b0100 && n < 60) begin
      @(negedge clock);
      n++;
    end
    check_eq("abort_find", {28'd0, dig_sel}, 32'b0100);
    enable = 1'b0;
    @(negedge clock);
    check_eq("abort_sel", {28'd0, dig_sel}, 32'd0);
    check_eq("abort_seg", {25'd0, seg}, 32'd0);
    check_eq("abort_tick", {31'd0, frame_tick}, 32'd0);
    ticks = 0;
    lit   = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (frame_tick) ticks++;
      if (dig_sel != '0 || seg != '0) lit++;
    end
    check_eq("idle_no_tick", ticks, 0);
    check_eq("idle_dark", lit, 0);
    enable = 1'b1;
    @(negedge clock);
    check_eq("reen_blank", {28'd0, dig_sel}, 32'd0);
    @(negedge clock);
    check_eq("reen_sel0", {28'd0, dig_sel}, 32'b0001);

    // Write to digit 3 on the commit edge is shown in the very next frame.
    n = 0;
    while (dig_sel != 4'b1000 && n < 60) begin
      @(negedge clock);
      n++;
    end
    repeat (PRESCALE - 1) @(negedge clock);
    check_eq("wt_last_show", {28'd0, dig_sel}, 32'b1000);
    wr_en   = 1'b1;
    wr_addr = 3'd3;
    wr_data = 4'd9;
    @(negedge clock);
    wr_en = 1'b0;
    check_eq("wt_tick", {31'd0, frame_tick}, 32'd1);
    check_eq("wt_ack", {31'd0, wr_ack}, 32'd1);
    push_exp(4'b0001, P0);
    push_exp(4'b0010, P0);
    push_exp(4'b0100, P5);
    push_exp(4'b1000, P9);
    check_frame("wt");

    // Reset mid-SHOW clears outputs and both register banks.
    n = 0;
    while (dig_sel == '0 && n < 20) begin
      @(negedge clock);
      n++;
    end
    reset = 1'b0;
    @(negedge clock);
    check_eq("mrst_seg", {25'd0, seg}, 32'd0);
    check_eq("mrst_sel", {28'd0, dig_sel}, 32'd0);
    check_eq("mrst_tick", {31'd0, frame_tick}, 32'd0);
    check_eq("mrst_ack", {31'd0, wr_ack}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    push_exp(4'b0001, P0);
    push_exp(4'b0010, P0);
    push_exp(4'b0100, P0);
    push_exp(4'b1000, P0);
    check_frame("mrst");

    check_eq("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
